button_switch_input_subsystem: RTL and testbench

- Input-side counterpart to the seven-segment output path. It captures board switches and push-buttons and makes them readable by the processor.
- Synchronizes and debounces every input. Detects button presses and keeps them as sticky event bits.
- Serves registered, single-cycle reads to the risc_v_32_i load path, with clear-on-read for events.
- Drives an `irq` level while any press is pending.

---
 rtl/button_switch_input_subsystem.sv | 150 +++++++++++++++
 tb/tb_button_switch_input_subsystem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_switch_input_subsystem.sv
// Board switch and push-button capture for the processor load path.
// Every pad is synchronized and debounced. Button presses latch into sticky
// event bits, which are cleared by reading them. A saturating counter tracks
// the total number of presses. irq stays high while any event is pending.
module button_switch_input_subsystem #(
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_SW-1:0]  sw,
    input  logic               rd_en,
    input  logic [1:0]         rd_sel,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               irq
);
    // Switches occupy the low bits and buttons the high bits of one
    // combined pad vector, so that a single debounce array serves both.
    localparam int NUM_IN = NUM_SW + NUM_BTN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0]  pad_all;
    logic [NUM_IN-1:0]  sync1_q;
    logic [NUM_IN-1:0]  sync2_q;
    logic [NUM_IN-1:0]  stable_q;
    logic [NUM_IN-1:0]  stable_d;
    logic [NUM_SW-1:0]  stable_sw;
    logic [NUM_BTN-1:0] stable_btn;
    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] event_q;
    logic [NUM_BTN-1:0] event_d;
    logic [NUM_BTN-1:0] ev_clear;
    logic [15:0]        press_count_q;
    logic [15:0]        press_count_d;
    logic [16:0]        rise_cnt;
    logic [16:0]        count_sum;
    logic [31:0]        rd_data_q;
    logic [31:0]        rd_data_d;
    logic               rd_valid_q;
    logic               irq_q;

    assign pad_all    = {btn, sw};
    assign stable_sw  = stable_q[NUM_SW-1:0];
    assign stable_btn = stable_q[NUM_IN-1:NUM_SW];

    // The two-flop synchronizer brings the asynchronous pads into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_all;
            sync2_q <= sync1_q;
        end
    end

    // Each bit has its own counter. The counter runs only while the
    // synchronized value differs from the accepted level. Any return to the
    // accepted level clears the counter, so short glitches are discarded.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next counter value and next accepted level for this bit.
            always_comb begin
                cnt_d        = '0;
                stable_d[gi] = stable_q[gi];
                if (sync2_q[gi] != stable_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d[gi] = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Register that holds the debounce counter.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // A press is a 0->1 change of the accepted button level. It is seen one
    // cycle after that level changes.
    assign btn_rise = stable_btn & ~btn_prev_q;

    // Add the number of new presses to the count, saturating at 16'hFFFF.
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rise_cnt = rise_cnt + 17'(btn_rise[i]);
        end
        count_sum     = 17'(press_count_q) + rise_cnt;
        press_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Read mux and clear-on-read. A new press beats the clear on the same edge.
    always_comb begin
        rd_data_d = rd_data_q;
        ev_clear  = '0;
        if (rd_en) begin
            case (rd_sel)
                2'd0: rd_data_d = 32'(stable_sw);
                2'd1: rd_data_d = 32'(stable_btn);
                2'd2: begin
                    rd_data_d = 32'(event_q);
                    ev_clear  = event_q;
                end
                default: rd_data_d = {16'b0, press_count_q};
            endcase
        end
        event_d = (event_q & ~ev_clear) | btn_rise;
    end

    // Registers for accepted levels, press tracking, read port and interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q      <= '0;
            btn_prev_q    <= '0;
            event_q       <= '0;
            press_count_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            stable_q      <= stable_d;
            btn_prev_q    <= stable_btn;
            event_q       <= event_d;
            press_count_q <= press_count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_en;
            irq_q         <= |event_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_button_switch_input_subsystem.sv
// Directed bench for button_switch_input_subsystem with DEBOUNCE_CYCLES=4.
// A behavioural model predicts rd_data, rd_valid and irq on every cycle.
// The model accepts a new level once the last DEBOUNCE_CYCLES synchronized
// samples all disagree with the current level. Literal checks pin the model.
module tb_button_switch_input_subsystem;
    localparam int NB = 5;
    localparam int NS = 16;
    localparam int DB = 4;
    localparam int CW = 20;
    localparam int NI = NS + NB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NS-1:0] sw = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_sel = 2'd0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_switch_input_subsystem #(
        .NUM_BTN(NB), .NUM_SW(NS), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .sw(sw),
        .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_hist[k] holds the pad vector that was sampled k+1 edges before the
    // current edge. Index 0 is the newest sample.
    logic [NI-1:0] m_hist [0:DB];
    logic [NS-1:0] m_sw_st = '0;
    logic [NB-1:0] m_btn_st = '0;
    logic [NB-1:0] m_pend = '0;
    logic [NB-1:0] m_ev = '0;
    int            m_count = 0;
    logic [31:0]   m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_irq = 1'b0;
    logic          force_req = 1'b0;
    logic          cmp_on = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= DB; k++) m_hist[k] <= '0;
            m_sw_st  <= '0;
            m_btn_st <= '0;
            m_pend   <= '0;
            m_ev     <= '0;
            m_count  <= 0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_irq    <= 1'b0;
        end else begin
            automatic logic [NI-1:0] st  = {m_btn_st, m_sw_st};
            automatic logic [NI-1:0] nst = {m_btn_st, m_sw_st};
            automatic logic [NB-1:0] ev  = m_ev;
            automatic int base = force_req ? 32'hFFFE : m_count;
            automatic int cnt;
            // Samples that have passed through the synchronizer: pad from 2..DB+1 edges ago.
            for (int b = 0; b < NI; b++) begin
                automatic bit flip = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    if (m_hist[j][b] == st[b]) flip = 1'b0;
                end
                if (flip) nst[b] = ~st[b];
            end
            if (rd_en) begin
                case (rd_sel)
                    2'd0: m_data <= 32'(m_sw_st);
                    2'd1: m_data <= 32'(m_btn_st);
                    2'd2: begin
                        m_data <= 32'(m_ev);
                        ev = '0;
                    end
                    default: m_data <= 32'(m_count);
                endcase
            end
            m_valid <= rd_en;
            ev  = ev | m_pend;
            cnt = base + $countones(m_pend);
            if (cnt > 65535) cnt = 65535;
            m_count  <= cnt;
            m_ev     <= ev;
            m_irq    <= |ev;
            m_pend   <= nst[NI-1:NS] & ~st[NI-1:NS];
            m_sw_st  <= nst[NS-1:0];
            m_btn_st <= nst[NI-1:NS];
            m_hist[0] <= {btn, sw};
            for (int k = 1; k <= DB; k++) m_hist[k] <= m_hist[k-1];
        end
    end

    // Per-cycle comparison of the outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_rd_data", rd_data, m_data);
            check("cyc_rd_valid", 32'(rd_valid), 32'(m_valid));
            check("cyc_irq", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_read(input logic [1:0] sel, output logic [31:0] d);
        rd_en  = 1'b1;
        rd_sel = sel;
        @(negedge clk);
        rd_en  = 1'b0;
        d = rd_data;
        $display("read sel=%0d data=%h valid=%0b irq=%0b", sel, rd_data, rd_valid, irq);
    endtask

    task automatic press(input logic [NB-1:0] mask, input int hi, input int lo);
        btn = mask;
        repeat (hi) @(negedge clk);
        btn = '0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        // Reset: the pads toggle while reset is held low.
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sw  = NS'($urandom);
            btn = NB'($urandom);
        end
        @(negedge clk);
        sw     = '0;
        btn    = '0;
        cmp_on = 1'b1;
        reset  = 1'b1;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        do_read(2'd3, d);
        check("rst_count", d, 32'h0);
        repeat (3) @(negedge clk);

        // Debounce latency. The read captured at edge 5 returns 0 and the
        // read captured at edge 6 returns the switch value.
        sw = 16'hA5C3;
        repeat (5) @(negedge clk);
        do_read(2'd0, d);
        check("sw_early", d, 32'h0);
        do_read(2'd0, d);
        check("sw_settled", d, 32'h0000A5C3);
        check("b2b_valid", 32'(rd_valid), 32'h1);
        @(negedge clk);
        check("hold_data", rd_data, 32'h0000A5C3);
        check("idle_valid", 32'(rd_valid), 32'h0);

        // Glitch rejection: btn[2] is high for only 3 cycles.
        press(5'b00100, 3, 10);
        do_read(2'd1, d);
        check("glitch_lvl", d, 32'h0);
        do_read(2'd2, d);
        check("glitch_ev", d, 32'h0);
        do_read(2'd3, d);
        check("glitch_cnt", d, 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        // Press btn[0] and btn[3] together, then clear the events by reading.
        btn = 5'b01001;
        repeat (10) @(negedge clk);
        check("press_irq", 32'(irq), 32'h1);
        btn = '0;
        repeat (8) @(negedge clk);
        do_read(2'd2, d);
        check("press_ev", d, 32'h9);
        do_read(2'd3, d);
        check("press_cnt", d, 32'h2);
        do_read(2'd2, d);
        check("cleared_ev", d, 32'h0);
        check("cleared_irq", 32'(irq), 32'h0);

        // Collision: the btn[4] event sets on the same edge that a read clears bit 0.
        press(5'b00001, 8, 8);
        btn = 5'b10000;
        repeat (6) @(negedge clk);
        do_read(2'd2, d);
        check("coll_first", d, 32'h1);
        do_read(2'd2, d);
        check("coll_second", d, 32'h10);
        btn = '0;
        repeat (8) @(negedge clk);
        do_read(2'd3, d);
        check("coll_cnt", d, 32'h4);

        // Saturation: force the count to FFFE, then apply three presses.
        force dut.press_count_q = 16'hFFFE;
        force_req = 1'b1;
        @(negedge clk);
        release dut.press_count_q;
        force_req = 1'b0;
        press(5'b00010, 8, 8);
        do_read(2'd3, d);
        check("sat_one", d, 32'h0000FFFF);
        press(5'b00010, 8, 8);
        press(5'b00010, 8, 8);
        do_read(2'd3, d);
        check("sat_cnt", d, 32'h0000FFFF);

        // Asynchronous reset while btn[2] is still being debounced.
        btn = 5'b00100;
        repeat (2) @(negedge clk);
        rd_en  = 1'b1;
        rd_sel = 2'd3;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        check("pre_rst_data", rd_data, 32'h0000FFFF);
        check("pre_rst_irq", 32'(irq), 32'h1);
        reset = 1'b0;
        #1;
        check("arst_data", rd_data, 32'h0);
        check("arst_valid", 32'(rd_valid), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        btn = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        do_read(2'd3, d);
        check("post_rst_cnt", d, 32'h0);
        do_read(2'd1, d);
        check("post_rst_btn", d, 32'h0);
        do_read(2'd2, d);
        check("post_rst_ev", d, 32'h0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
